// File: rtl/coproc_dispatch.sv
// coproc_dispatch: walks a list of triangles for one ray, fetching each
// triangle, handing it to the intersection coprocessor and keeping the
// nearest accepted hit.
// Optional feature: define COPROC_DISPATCH_TIMEOUT_EN to bound the wait for
// the coprocessor to 1024 cycles (flags Error and ends the traversal).
module coproc_dispatch #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Go,
  input  logic [IDX_W-1:0]    TriCount,
  input  logic [6*DATA_W-1:0] RayIn,
  output logic [IDX_W-1:0]    TriIndex,
  output logic                TriReq,
  input  logic                TriAck,
  input  logic [9*DATA_W-1:0] TriVerts,
  output logic                CpStart,
  output logic [6*DATA_W-1:0] CpRay,
  output logic [9*DATA_W-1:0] CpTri,
  input  logic                CpReady,
  input  logic [1:0]          CpCode,
  input  logic [DATA_W-1:0]   CpT,
  input  logic [3*DATA_W-1:0] CpPoint,
  output logic                Busy,
  output logic                Done,
  output logic                HitValid,
  output logic [IDX_W-1:0]    HitIndex,
  output logic [DATA_W-1:0]   HitT,
  output logic [3*DATA_W-1:0] HitPoint,
  output logic                Error
);

  localparam logic [1:0] CODE_HIT = 2'b01;
  localparam logic [1:0] CODE_ERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    UPDATE = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t              state;
  state_t              stateNext;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    triCnt;
  logic                waitFirst;
  logic [1:0]          resCode;
  logic [DATA_W-1:0]   resT;
  logic [3*DATA_W-1:0] resPoint;
  logic                lastTri;
  logic                resultIn;
`ifdef COPROC_DISPATCH_TIMEOUT_EN
  logic [9:0]          waitCnt;
`endif

  // A hit is taken only if it is a real hit with non-negative distance that is
  // strictly nearer than the best so far; the positive-float bit patterns order
  // the same as unsigned integers, and a tie keeps the earlier triangle.
  function automatic logic acceptHit(input logic [1:0] code,
                                     input logic [DATA_W-1:0] t,
                                     input logic haveHit,
                                     input logic [DATA_W-1:0] bestT);
    return (code == CODE_HIT) && !t[DATA_W-1] && (!haveHit || (t < bestT));
  endfunction

  assign lastTri  = (idx == (triCnt - {{(IDX_W-1){1'b0}}, 1'b1}));
  // The cycle right after CpStart may still show the previous result level.
  assign resultIn = (state == WAIT) && !waitFirst && CpReady;
  assign TriIndex = idx;
  assign TriReq   = (state == FETCH);
  assign CpStart  = (state == ISSUE) && CpReady;
  assign Busy     = (state != IDLE);

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state decode.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:   if (Go) stateNext = (TriCount == '0) ? DONE : FETCH;
      FETCH:  if (TriAck) stateNext = ISSUE;
      ISSUE:  if (CpReady) stateNext = WAIT;
      WAIT: begin
        if (resultIn) stateNext = UPDATE;
`ifdef COPROC_DISPATCH_TIMEOUT_EN
        else if (waitCnt == '1) stateNext = DONE;
`endif
      end
      UPDATE: stateNext = lastTri ? DONE : FETCH;
      DONE:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Traversal datapath: ray/triangle capture, result capture, best-hit update.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      idx       <= '0;
      triCnt    <= '0;
      waitFirst <= 1'b0;
      resCode   <= '0;
      resT      <= '0;
      resPoint  <= '0;
      CpRay     <= '0;
      CpTri     <= '0;
      Done      <= 1'b0;
      HitValid  <= 1'b0;
      HitIndex  <= '0;
      HitT      <= '0;
      HitPoint  <= '0;
      Error     <= 1'b0;
`ifdef COPROC_DISPATCH_TIMEOUT_EN
      waitCnt   <= '0;
`endif
    end else begin
      Done <= (state == DONE);
      case (state)
        IDLE: begin
          if (Go) begin
            CpRay    <= RayIn;
            triCnt   <= TriCount;
            idx      <= '0;
            HitValid <= 1'b0;
            Error    <= 1'b0;
          end
        end
        FETCH: begin
          if (TriAck) CpTri <= TriVerts;
        end
        ISSUE: begin
          if (CpReady) begin
            waitFirst <= 1'b1;
`ifdef COPROC_DISPATCH_TIMEOUT_EN
            waitCnt   <= '0;
`endif
          end
        end
        WAIT: begin
          waitFirst <= 1'b0;
          if (resultIn) begin
            resCode  <= CpCode;
            resT     <= CpT;
            resPoint <= CpPoint;
          end
`ifdef COPROC_DISPATCH_TIMEOUT_EN
          else begin
            waitCnt <= waitCnt + 10'd1;
            if (waitCnt == '1) Error <= 1'b1;
          end
`endif
        end
        UPDATE: begin
          if (acceptHit(resCode, resT, HitValid, HitT)) begin
            HitValid <= 1'b1;
            HitIndex <= idx;
            HitT     <= resT;
            HitPoint <= resPoint;
          end
          if (resCode == CODE_ERR) Error <= 1'b1;
          if (!lastTri) idx <= idx + {{(IDX_W-1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

endmodule
